mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Dual-port memory model/responder serving the core's instruction-fetch and data-access request interfaces.
- Owns a word-addressed storage array. The imem port is read-only; the dmem port supports byte-masked reads and writes.
- Each port has its own latency counter and single-cycle resp pulse.
- Sits at the top level opposite the core, replacing the external memory for simulation and FPGA bring-up.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the storage array (power of two).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- IMEM_LATENCY, 2, cycles from request acceptance to imem_resp (≥1).
- DMEM_LATENCY, 3, cycles from request acceptance to dmem_resp (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_addr  in  32  fetch byte address; bits [1:0] ignored
- imem_rmask  in  4  fetch read mask; nonzero = request
- imem_rdata  out  32  fetch data, valid when imem_resp=1
- imem_resp  out  1  one-cycle fetch completion pulse
- dmem_addr  in  32  data byte address; bits [1:0] ignored
- dmem_rmask  in  4  data read mask; nonzero = read request
- dmem_wmask  in  4  data byte write enables; nonzero = write request
- dmem_wdata  in  32  write data, byte lanes selected by dmem_wmask
- dmem_rdata  out  32  read data, valid when dmem_resp=1
- dmem_resp  out  1  one-cycle data completion pulse
- oob_err  out  1  sticky: an accepted request was outside the mapped range
- proto_err  out  1  sticky: a protocol violation occurred (see below)

Behaviour:
- Reset values: imem_resp=0, dmem_resp=0, imem_rdata=0, dmem_rdata=0, oob_err=0, proto_err=0. Both port FSMs go to IDLE.
- Reset does not clear the storage array. Array contents are X until written; a $readmemh preload is allowed in simulation only.
- Per-port FSM states: IDLE, BUSY (down-counter), RESP.
- Request acceptance:
  - A port accepts a request in cycle T when it is in IDLE or RESP, rst=0, and its mask is nonzero.
  - Request signals are sampled only at T. The initiator need not hold them afterwards.
- Access timing:
  - Reads snapshot the full 32-bit word at T into a per-port data register.
  - Writes commit to the array at the clock edge ending cycle T.
- Response:
  - resp=1 for exactly one cycle, T+LATENCY. rdata holds the snapshot during that cycle and holds its last value otherwise.
  - With LATENCY=1: FSM goes IDLE→RESP directly.
  - Otherwise: BUSY counts LATENCY-1 down to 1, then RESP.
- Back-to-back: a new request may be accepted in the RESP cycle, giving sustained throughput of one response per LATENCY cycles.
- Reads return all 4 bytes regardless of rmask. The initiator extracts lanes itself.
- Writes update only the bytes enabled by wmask. On a write response, dmem_rdata=0.
- dmem with both rmask≠0 and wmask≠0:
  - Treated as a write only; the read is not performed.
  - proto_err is set.
- Request while BUSY (mask nonzero, port not IDLE/RESP):
  - Ignored; the in-flight request is unaffected.
  - proto_err is set.
- Out of range: word index (addr-BASE_ADDR)>>2 ≥ DEPTH_WORDS, or addr<BASE_ADDR.
  - The request is still accepted and responded to at normal latency.
  - Read data = 0; the write is dropped.
  - oob_err is set.
- Same-cycle collision: when imem read and dmem write are accepted in the same cycle T to the same word, imem returns the pre-write data (read-before-write). Same rule applies to a dmem write at T and a dmem read accepted at a later cycle: the later read sees the new data.
- Reset mid-operation:
  - In-flight requests are discarded with no resp pulse.
  - Writes already committed remain in the array.
- Error flags are cleared only by rst.
- Address arithmetic: 32-bit unsigned subtract; index width = $clog2(DEPTH_WORDS).

Test Plan:
- Basic write/read:
  - dmem write wmask=4'hF, addr=0x10, wdata=0xDEADBEEF at cycle T → dmem_resp at T+3.
  - dmem read of 0x10 → rdata=0xDEADBEEF three cycles after acceptance.
  - imem read of 0x10 → imem_resp two cycles after acceptance with the same data.
- Byte masking: preload 0x11223344 at 0x20; write wmask=4'b0101, wdata=0xAABBCCDD → read returns 0x11BB33DD.
- Collision: word 0x30=0x0; same cycle: imem read 0x30 and dmem write 0xFFFFFFFF to 0x30 → imem_rdata=0x0; subsequent imem read returns 0xFFFFFFFF.
- Back-to-back throughput: 8 imem reads, each issued in the previous resp cycle → exactly 8 resp pulses spaced 2 cycles apart, data in order, proto_err=0.
- Errors:
  - Read of BASE_ADDR+4*DEPTH_WORDS → resp with rdata=0, oob_err=1.
  - dmem request while BUSY → proto_err=1, original resp still arrives on time.
  - dmem rmask=wmask=4'hF → write performed, proto_err=1.
- Reset mid-flight: accept dmem write to 0x40 then assert rst at T+1 → no dmem_resp, all outputs zero, later read of 0x40 returns the written data.

Source files
------------

// File: rtl/mem_responder.sv
// Dual-port memory responder: read-only fetch port and byte-masked data port over a shared word array.
// Each port runs its own latency FSM and produces a single-cycle resp pulse.

module mem_port_fsm #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] rd_word,
    output logic        accept,
    output logic        busy_req,
    output logic        resp,
    output logic [31:0] rdata
);
    // state | meaning
    // IDLE  | no request in flight
    // BUSY  | request accepted, counting down remaining latency
    // RESP  | response cycle; a new request may be accepted here
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        snap_q;
    logic [31:0]        rdata_q;

    assign accept   = req && !rst && (state_q != BUSY);
    assign busy_req = req && !rst && (state_q == BUSY);
    assign resp     = (state_q == RESP);
    assign rdata    = rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) state_d = RESP;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // rdata only moves on the edge entering RESP so it is stable between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) snap_q <= rd_word;
            if (state_d == RESP) rdata_q <= (LATENCY == 1) ? rd_word : snap_q;
        end
    end
endmodule

module mem_responder #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          IMEM_LATENCY = 2,
    parameter int          DMEM_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        oob_err,
    output logic        proto_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic             imem_req, dmem_req, dmem_is_wr, dmem_both;
    logic [30:0]      imem_diff, dmem_diff;
    logic             imem_oob, dmem_oob;
    logic [IDX_W-1:0] imem_idx, dmem_idx;
    logic [31:0]      imem_word, dmem_word;
    logic             imem_accept, dmem_accept;
    logic             imem_busy_req, dmem_busy_req;
    logic             dmem_wr_en;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{imem_addr[1:0], dmem_addr[1:0]};

    assign imem_req   = |imem_rmask;
    assign dmem_is_wr = |dmem_wmask;
    assign dmem_req   = (|dmem_rmask) || dmem_is_wr;
    assign dmem_both  = (|dmem_rmask) && dmem_is_wr;

    // Word-granular subtract; the extra top bit is the borrow for addresses below BASE_ADDR.
    assign imem_diff = {1'b0, imem_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign dmem_diff = {1'b0, dmem_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign imem_oob  = imem_diff[30] || (imem_diff[29:0] >= 30'(DEPTH_WORDS));
    assign dmem_oob  = dmem_diff[30] || (dmem_diff[29:0] >= 30'(DEPTH_WORDS));
    assign imem_idx  = imem_diff[IDX_W-1:0];
    assign dmem_idx  = dmem_diff[IDX_W-1:0];

    // Combinational read before the write edge gives read-before-write on collisions.
    assign imem_word = imem_oob ? 32'h0 : mem[imem_idx];
    assign dmem_word = (dmem_oob || dmem_is_wr) ? 32'h0 : mem[dmem_idx];

    mem_port_fsm #(.LATENCY(IMEM_LATENCY)) u_imem_fsm (
        .clk      (clk),
        .rst      (rst),
        .req      (imem_req),
        .rd_word  (imem_word),
        .accept   (imem_accept),
        .busy_req (imem_busy_req),
        .resp     (imem_resp),
        .rdata    (imem_rdata)
    );

    mem_port_fsm #(.LATENCY(DMEM_LATENCY)) u_dmem_fsm (
        .clk      (clk),
        .rst      (rst),
        .req      (dmem_req),
        .rd_word  (dmem_word),
        .accept   (dmem_accept),
        .busy_req (dmem_busy_req),
        .resp     (dmem_resp),
        .rdata    (dmem_rdata)
    );

    assign dmem_wr_en = dmem_accept && dmem_is_wr && !dmem_oob;

    always_ff @(posedge clk) begin
        if (dmem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wmask[b]) mem[dmem_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if ((imem_accept && imem_oob) || (dmem_accept && dmem_oob)) oob_err <= 1'b1;
            if (imem_busy_req || dmem_busy_req || dmem_both)             proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses, a monitor pops and compares.

module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_rmask = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        oob_err;
    logic        proto_err;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .oob_err    (oob_err),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every resp pulse must match the oldest expected entry in data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (imem_resp) begin
            if (iq.size() == 0) begin
                checks++; fails++;
                $display("FAIL imem_unexpected_resp: got resp with data %h expected none (cycle %0d)", imem_rdata, cyc);
            end else begin
                e = iq.pop_front();
                chk("imem_rdata", imem_rdata, e.data);
                chk("imem_resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (dmem_resp) begin
            if (dq.size() == 0) begin
                checks++; fails++;
                $display("FAIL dmem_unexpected_resp: got resp with data %h expected none (cycle %0d)", dmem_rdata, cyc);
            end else begin
                e = dq.pop_front();
                chk("dmem_rdata", dmem_rdata, e.data);
                chk("dmem_resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issues one dmem request and returns at the negedge of its response cycle minus one,
    // so the next call lands exactly in the RESP cycle.
    task automatic dm_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                          input logic [31:0] wd, input logic [31:0] exp);
        @(negedge clk);
        dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
        dq.push_back('{exp, cyc + 3});
        @(negedge clk);
        dmem_rmask = '0; dmem_wmask = '0;
        @(negedge clk);
    endtask

    task automatic im_req(input logic [31:0] a, input logic [3:0] rm, input logic [31:0] exp);
        @(negedge clk);
        imem_addr = a; imem_rmask = rm;
        iq.push_back('{exp, cyc + 2});
        @(negedge clk);
        imem_rmask = '0;
    endtask

    task automatic do_reset();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_imem_resp"},  32'(imem_resp),  32'h0);
        chk({tag, "_dmem_resp"},  32'(dmem_resp),  32'h0);
        chk({tag, "_imem_rdata"}, imem_rdata,      32'h0);
        chk({tag, "_dmem_rdata"}, dmem_rdata,      32'h0);
        chk({tag, "_oob_err"},    32'(oob_err),    32'h0);
        chk({tag, "_proto_err"},  32'(proto_err),  32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // basic write/read through both ports
        dm_req(32'h10, 4'h0, 4'hF, 32'hDEAD_BEEF, 32'h0);
        dm_req(32'h10, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF);
        im_req(32'h10, 4'hF, 32'hDEAD_BEEF);
        im_req(32'h12, 4'h1, 32'hDEAD_BEEF);

        // byte masking
        dm_req(32'h20, 4'h0, 4'hF, 32'h1122_3344, 32'h0);
        dm_req(32'h20, 4'h0, 4'b0101, 32'hAABB_CCDD, 32'h0);
        dm_req(32'h20, 4'h3, 4'h0, 32'h0, 32'h11BB_33DD);

        // same-cycle collision: fetch sees pre-write data
        dm_req(32'h30, 4'h0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        imem_addr = 32'h30; imem_rmask = 4'hF;
        dmem_addr = 32'h30; dmem_wmask = 4'hF; dmem_wdata = 32'hFFFF_FFFF;
        iq.push_back('{32'h0, cyc + 2});
        dq.push_back('{32'h0, cyc + 3});
        @(negedge clk);
        imem_rmask = '0; dmem_wmask = '0;
        @(negedge clk);
        im_req(32'h30, 4'hF, 32'hFFFF_FFFF);
        dm_req(32'h30, 4'hF, 4'h0, 32'h0, 32'hFFFF_FFFF);

        // back-to-back fetch throughput
        for (int i = 0; i < 8; i++) dm_req(32'h100 + 32'(4*i), 4'h0, 4'hF, 32'h1000_0000 + 32'(i), 32'h0);
        for (int i = 0; i < 8; i++) im_req(32'h100 + 32'(4*i), 4'hF, 32'h1000_0000 + 32'(i));
        repeat (3) @(negedge clk);
        chk("b2b_proto_err", 32'(proto_err), 32'h0);
        chk("b2b_oob_err_before", 32'(oob_err), 32'h0);

        // out of range: read returns zero, write is dropped instead of aliasing word 0
        dm_req(32'h0, 4'h0, 4'hF, 32'h0, 32'h0);
        im_req(32'h1000, 4'hF, 32'h0);
        repeat (2) @(negedge clk);
        chk("oob_err_after_imem", 32'(oob_err), 32'h1);
        dm_req(32'h1000, 4'h0, 4'hF, 32'h5555_5555, 32'h0);
        dm_req(32'h0, 4'hF, 4'h0, 32'h0, 32'h0);
        dm_req(32'hFFFF_FFFC, 4'hF, 4'h0, 32'h0, 32'h0);

        // request while busy is ignored and flagged
        chk("busy_proto_err_before", 32'(proto_err), 32'h0);
        @(negedge clk);
        dmem_addr = 32'h10; dmem_rmask = 4'hF;
        dq.push_back('{32'hDEAD_BEEF, cyc + 3});
        @(negedge clk);
        dmem_rmask = '0; dmem_wmask = 4'hF; dmem_wdata = 32'h1234_5678;
        @(negedge clk);
        dmem_wmask = '0;
        @(negedge clk);
        chk("busy_proto_err", 32'(proto_err), 32'h1);
        dm_req(32'h10, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF);

        // read+write together is a write, flagged
        do_reset();
        chk("rw_proto_err_before", 32'(proto_err), 32'h0);
        chk("rw_oob_err_cleared", 32'(oob_err), 32'h0);
        dm_req(32'h50, 4'hF, 4'hF, 32'hCAFE_F00D, 32'h0);
        chk("rw_proto_err", 32'(proto_err), 32'h1);
        dm_req(32'h50, 4'hF, 4'h0, 32'h0, 32'hCAFE_F00D);
        dm_req(32'h10, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF);

        // reset mid-flight drops the response but keeps the committed write
        do_reset();
        @(negedge clk);
        dmem_addr = 32'h40; dmem_wmask = 4'hF; dmem_wdata = 32'h0BAD_C0DE;
        @(negedge clk);
        dmem_wmask = '0; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_outputs_zero("midflight");
        @(negedge clk);
        rst = 1'b0;
        dm_req(32'h40, 4'hF, 4'h0, 32'h0, 32'h0BAD_C0DE);
        im_req(32'h40, 4'hF, 32'h0BAD_C0DE);

        repeat (6) @(negedge clk);
        chk("imem_pending_at_end", 32'(iq.size()), 32'h0);
        chk("dmem_pending_at_end", 32'(dq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
